// File: rtl/aes_dec_sched_pkg.sv
// Shared definitions for the AES decrypt-core scheduler.
package aes_ctrl_pkg;
  localparam int AES_BLK_W = 128;
  localparam int DEC_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/aes_dec_sched_if.sv
// Requester ports and decrypt-core handshake of the scheduler, bundled as one interface.
interface aes_dec_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]                        req_valid_i;
  logic [NREQ*aes_ctrl_pkg::AES_BLK_W-1:0] req_data_i;
  logic [NREQ-1:0]                        req_ready_o;
  logic [NREQ-1:0]                        rsp_valid_o;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]     rsp_data_o;
  logic                                   rsp_err_o;
  logic [NREQ-1:0]                        rsp_ready_i;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]     ciphertext_o;
  logic                                   dec_cs_o;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]     plaintext_i;
  logic                                   dec_done_i;
  logic                                   busy_o;

  modport master (
    output req_valid_i, req_data_i, rsp_ready_i, plaintext_i, dec_done_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, ciphertext_o, dec_cs_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i, plaintext_i, dec_done_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, ciphertext_o, dec_cs_o, busy_o
  );
endinterface

// File: rtl/aes_dec_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end
endmodule

// File: rtl/aes_dec_sched.sv
// Round-robin scheduler sharing one AES-128 decrypt core among NREQ requesters.
// state | meaning
// IDLE  | arbitrate and accept one request
// ISSUE | one-cycle dec_cs pulse to the core
// WAIT  | wait for done rising edge or timeout
// RESP  | hold response until the owner accepts it
module aes_dec_sched
  import aes_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  aes_dec_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr, owner, gnt_idx;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_any, done_q, done_rise, timeout_hit, rsp_hs;
  logic [CW-1:0]        tmo_cnt;
  logic [AES_BLK_W-1:0] ct_q, pt_q;
  logic                 err_q;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (bus.req_valid_i),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign done_rise   = bus.dec_done_i & ~done_q;
  assign timeout_hit = (tmo_cnt == CW'(TIMEOUT - 1));
  assign rsp_hs      = (state == S_RESP) & bus.rsp_ready_i[owner];

  always_comb begin
    state_nxt       = state;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.dec_cs_o    = 1'b0;
    case (state)
      S_IDLE: begin
        // ready equals the grant, so a handshake happens whenever anything is granted
        if (wb_rst_ni) bus.req_ready_o = gnt;
        if (gnt_any) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.dec_cs_o = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: if (done_rise || timeout_hit) state_nxt = S_RESP;
      S_RESP: begin
        bus.rsp_valid_o[owner] = 1'b1;
        if (rsp_hs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      tmo_cnt <= '0;
      done_q  <= 1'b0;
      ct_q    <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= bus.dec_done_i;
      case (state)
        S_IDLE: if (gnt_any) begin
          owner <= gnt_idx;
          ct_q  <= bus.req_data_i[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          // completion takes priority over a simultaneous timeout
          if (done_rise) begin
            pt_q  <= bus.plaintext_i;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            pt_q  <= '0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: if (rsp_hs) rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy_o       = (state != S_IDLE);
  assign bus.ciphertext_o = ct_q;
  assign bus.rsp_data_o   = pt_q;
  assign bus.rsp_err_o    = err_q;
endmodule

// File: tb/tb_aes_dec_sched.sv
// Self-checking bench for aes_dec_sched: vector table, scoreboard, corner-case sequences.
`timescale 1ns/1ps
module tb_aes_dec_sched;
  import aes_ctrl_pkg::*;
  localparam int NREQ = 4;
  localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KMASK = CT1 ^ PT1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aes_dec_sched_if #(.NREQ(NREQ)) bus ();
  aes_dec_sched_if #(.NREQ(NREQ)) b16 ();

  aes_dec_sched #(.NREQ(NREQ), .TIMEOUT(64), .CW(7)) u_dut (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .bus (bus)
  );
  aes_dec_sched #(.NREQ(NREQ), .TIMEOUT(16), .CW(5)) u_dut16 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .bus (b16)
  );

  typedef struct { int idx; logic [127:0] data; logic err; } exp_t;
  typedef struct { int idx; logic [127:0] ct; int lat; logic [127:0] pt; } vec_t;

  exp_t sb[$];
  int   glog[$];
  int   n_tests = 0, n_fail = 0;
  int   ptr_m = 0, cs_cnt = 0;
  bit   mon_en = 1'b0;
  int   core_lat = 5;
  bit   core_hold = 1'b0, core_busy = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int rr_pick(logic [3:0] v, int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // grant prediction and response scoreboard, sampled mid-cycle
  always @(posedge clk) begin
    int g;
    logic [3:0] exp_g;
    exp_t e;
    #2;
    if (mon_en) begin
      if (bus.dec_cs_o) cs_cnt++;
      if (|bus.req_ready_o) begin
        g = rr_pick(bus.req_valid_i, ptr_m);
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("grant", bus.req_ready_o, exp_g);
        if (g >= 0) begin
          sb.push_back('{g, bus.req_data_i[g*128 +: 128] ^ KMASK, 1'b0});
          glog.push_back(g);
        end
      end
      if (|(bus.rsp_valid_o & bus.rsp_ready_i)) begin
        if (sb.size() == 0) check("rsp_unexpected", bus.rsp_valid_o, 0);
        else begin
          e = sb.pop_front();
          check("sb_owner", bus.rsp_valid_o, 128'(4'b1 << e.idx));
          check("sb_data", bus.rsp_data_o, e.data);
          check("sb_err", bus.rsp_err_o, e.err);
          ptr_m = (e.idx + 1) % NREQ;
        end
      end
    end
  end

  // decrypt core model: plaintext = ciphertext ^ KMASK after core_lat cycles
  initial begin
    logic [127:0] c;
    bus.dec_done_i  = 1'b0;
    bus.plaintext_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.dec_cs_o) begin
        c = bus.ciphertext_o;
        core_busy = 1'b1;
        repeat (core_lat - 1) begin @(posedge clk); #1; end
        bus.dec_done_i = 1'b0;
        @(posedge clk); #1;
        bus.plaintext_i = c ^ KMASK;
        bus.dec_done_i  = 1'b1;
        @(posedge clk); #1;
        if (!core_hold) bus.dec_done_i = 1'b0;
        core_busy = 1'b0;
      end
    end
  end

  task automatic run_single(string tag, int idx, logic [127:0] ct, int lat, logic [127:0] exp_pt);
    int k, cs0;
    bit got;
    core_lat = lat;
    cs0 = cs_cnt;
    bus.req_data_i[idx*128 +: 128] = ct;
    bus.req_valid_i[idx] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (bus.req_ready_o[idx]) got = 1'b1;
      @(posedge clk); #1;
    end
    bus.req_valid_i[idx] = 1'b0;
    if (!got) begin
      check({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    check({tag, "_cs"}, bus.dec_cs_o, 1);
    for (k = 0; k < 100; k++) begin
      step();
      if (|bus.rsp_valid_o) break;
    end
    check({tag, "_latency"}, k + 1, lat + 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid_o, 128'(4'b1 << idx));
    check({tag, "_rsp_data"}, bus.rsp_data_o, exp_pt);
    check({tag, "_rsp_err"}, bus.rsp_err_o, 0);
    check({tag, "_cs_count"}, cs_cnt - cs0, 1);
    step();
  endtask

  task automatic run_burst(string tag, logic [3:0] mask, int n, bit drop, int lat);
    int base;
    bit done;
    base = glog.size();
    core_lat = lat;
    for (int j = 0; j < NREQ; j++) bus.req_data_i[j*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid_i = mask;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      if (drop) for (int j = base; j < glog.size(); j++) bus.req_valid_i[glog[j]] = 1'b0;
      if (glog.size() - base >= n) bus.req_valid_i = '0;
      if (glog.size() - base >= n && sb.size() == 0 && !bus.busy_o) done = 1'b1;
    end
    if (!done) check({tag, "_budget"}, 0, 1);
  endtask

  task automatic run16(string tag, int idx, int lat, logic [127:0] pt, logic exp_err,
                       logic [127:0] exp_data, int exp_wait);
    int nwait;
    bit got;
    b16.req_data_i[idx*128 +: 128] = {4{32'hc0de0000 + 32'(idx)}};
    b16.req_valid_i[idx] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      #1;
      if (b16.req_ready_o[idx]) got = 1'b1;
      @(posedge clk); #1;
    end
    b16.req_valid_i[idx] = 1'b0;
    check({tag, "_cs"}, b16.dec_cs_o, 1);
    nwait = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (|b16.rsp_valid_o) break;
      if (b16.busy_o && !b16.dec_cs_o) nwait++;
      if (lat > 0 && k == lat) begin
        b16.plaintext_i = pt;
        b16.dec_done_i  = 1'b1;
      end
    end
    b16.dec_done_i = 1'b0;
    check({tag, "_wait_cycles"}, nwait, exp_wait);
    check({tag, "_rsp_valid"}, b16.rsp_valid_o, 128'(4'b1 << idx));
    check({tag, "_rsp_err"}, b16.rsp_err_o, exp_err);
    check({tag, "_rsp_data"}, b16.rsp_data_o, exp_data);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   e2[5];
    bit   stable, got;
    int   cs0;
    logic [127:0] ct5a, ct5b, ct6, ct6b;

    vt[0] = '{0, CT1, 20, PT1};
    vt[1] = '{2, 128'hdeadbeef_01234567_89abcdef_fedcba98, 3,
              128'hdeadbeef_01234567_89abcdef_fedcba98 ^ KMASK};
    vt[2] = '{1, 128'h0, 7, KMASK};
    vt[3] = '{3, {128{1'b1}}, 2, ~KMASK};
    e2 = '{0, 1, 2, 3, 0};
    ct5a = 128'h5555aaaa_5555aaaa_12345678_9abcdef0;
    ct5b = 128'h0f0f0f0f_f0f0f0f0_11112222_33334444;
    ct6  = 128'h66666666_77777777_88888888_99999999;
    ct6b = 128'hcafebabe_00000000_ffffffff_13579bdf;

    bus.req_valid_i = '0; bus.req_data_i = '0; bus.rsp_ready_i = '1;
    b16.req_valid_i = '0; b16.req_data_i = '0; b16.rsp_ready_i = '1;
    b16.dec_done_i = 1'b0; b16.plaintext_i = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_data", bus.rsp_data_o, 0);
    check("rst_rsp_err", bus.rsp_err_o, 0);
    check("rst_ciphertext", bus.ciphertext_o, 0);
    check("rst_dec_cs", bus.dec_cs_o, 0);
    check("rst_busy", bus.busy_o, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // single-request vectors
    for (int i = 0; i < 4; i++) run_single("vec", vt[i].idx, vt[i].ct, vt[i].lat, vt[i].pt);

    // all four requesters valid continuously
    run_burst("t2", 4'b1111, 5, 1'b0, 5);
    for (int i = 0; i < 5; i++) check("t2_order", glog[glog.size() - 5 + i], e2[i]);

    // bring pointer to 2, then only req1 and req3 pending -> 3 first, then 1
    run_single("t3_pre", 1, 128'h1, 3, 128'h1 ^ KMASK);
    run_burst("t3", 4'b1010, 2, 1'b1, 4);
    check("t3_first", glog[glog.size() - 2], 3);
    check("t3_second", glog[glog.size() - 1], 1);

    // response back-pressure with done held high afterwards
    bus.rsp_ready_i = '0;
    core_hold = 1'b1;
    cs0 = cs_cnt;
    run_single("t5a", 2, ct5a, 4, ct5a ^ KMASK);
    cs0 = cs_cnt;
    stable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (bus.rsp_valid_o !== 4'b0100 || bus.rsp_data_o !== (ct5a ^ KMASK) ||
          bus.dec_cs_o || !bus.busy_o) stable = 1'b0;
    end
    check("t5_stall_stable", stable, 1);
    check("t5_no_cs", cs_cnt - cs0, 0);
    bus.rsp_ready_i = '1;
    step();
    step();
    core_hold = 1'b0;
    check("t5_done_still_high", bus.dec_done_i, 1);
    run_single("t5b", 0, ct5b, 6, ct5b ^ KMASK);

    // reset while in WAIT
    core_lat = 20;
    bus.req_data_i[1*128 +: 128] = ct6;
    bus.req_valid_i[1] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      step();
      if (bus.dec_cs_o) got = 1'b1;
    end
    bus.req_valid_i[1] = 1'b0;
    check("t6_issued", got, 1);
    repeat (3) step();
    bus.req_valid_i[2] = 1'b1;
    rst_n = 1'b0;
    sb.delete();
    ptr_m = 0;
    #1;
    check("t6_req_ready", bus.req_ready_o, 0);
    check("t6_rsp_valid", bus.rsp_valid_o, 0);
    check("t6_rsp_data", bus.rsp_data_o, 0);
    check("t6_rsp_err", bus.rsp_err_o, 0);
    check("t6_ciphertext", bus.ciphertext_o, 0);
    check("t6_dec_cs", bus.dec_cs_o, 0);
    check("t6_busy", bus.busy_o, 0);
    step();
    bus.req_valid_i[2] = 1'b0;
    step();
    rst_n = 1'b1;
    for (int w = 0; w < 40 && core_busy; w++) step();
    step();
    check("t6_idle_after", bus.busy_o, 0);
    run_single("t6_post", 3, ct6b, 4, ct6b ^ KMASK);

    // timeout on the TIMEOUT=16 instance, tie with completion, then a normal op
    run16("t4_timeout", 0, 0, '0, 1'b1, '0, 16);
    run16("t4_tie", 1, 16, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 1'b0,
          128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 16);
    run16("t4_next", 2, 5, PT1, 1'b0, PT1, 5);

    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
